// File: rtl/ram_arb2_pkg.sv
// Shared constants and types for the two-port RAM arbiter and its bench.
// Holds the default widths, the read latency and the owner-tag types.
package ram_arb2_pkg;

    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned DATA_W_DEF = 8;

    // Cycles from the grant cycle to the rvalid pulse.
    localparam int unsigned RD_LAT     = 2;
    localparam int unsigned TAG_STAGES = RD_LAT;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    typedef struct packed {
        logic  valid;
        port_e port;
    } tag_t;

    function automatic port_e other_port(input port_e p);
        return (p == PORT_A) ? PORT_B : PORT_A;
    endfunction

endpackage

// File: rtl/ram_arb2_rr_arb2.sv
// Two-requester round-robin arbiter. The grants are combinational from the
// requests and the priority pointer; the pointer moves only on an accepted grant.
module rr_arb2
    import ram_arb2_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic a_req,
    input  logic b_req,
    output logic a_gnt,
    output logic b_gnt
);

    port_e prio_q;
    port_e prio_d;

    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (rst_n) begin
            if (a_req && b_req) begin
                a_gnt = (prio_q == PORT_A);
                b_gnt = (prio_q == PORT_B);
            end else begin
                a_gnt = a_req;
                b_gnt = b_req;
            end
        end
    end

    // The port that was just served loses priority on the next contention.
    always_comb begin
        prio_d = prio_q;
        if (a_gnt) begin
            prio_d = other_port(PORT_A);
        end else if (b_gnt) begin
            prio_d = other_port(PORT_B);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_q <= PORT_A;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/ram_arb2.sv
// Two-port arbiter in front of a single-port RAM: registered command stage,
// owner-tag pipeline to route read data back to the requesting port.
module ram_arb2
    import ram_arb2_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,

    output logic              ram_wr_en,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    input  logic [DATA_W-1:0] ram_rd_data
);

    logic              accept;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    port_e             sel_port;

    logic              ram_wr_en_q,   ram_wr_en_d;
    logic              ram_rd_en_q,   ram_rd_en_d;
    logic [ADDR_W-1:0] ram_addr_q,    ram_addr_d;
    logic [DATA_W-1:0] ram_wr_data_q, ram_wr_data_d;

    tag_t              tag_q [TAG_STAGES];
    tag_t              tag_d [TAG_STAGES];
    tag_t              out_tag;

    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

    rr_arb2 u_arb (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .a_req (a_req),
        .b_req (b_req),
        .a_gnt (a_gnt),
        .b_gnt (b_gnt)
    );

    always_comb begin
        accept    = a_gnt | b_gnt;
        sel_port  = b_gnt ? PORT_B : PORT_A;
        sel_we    = b_gnt ? b_we    : a_we;
        sel_addr  = b_gnt ? b_addr  : a_addr;
        sel_wdata = b_gnt ? b_wdata : a_wdata;
    end

    // Enables pulse for one cycle per accepted access; address and data hold otherwise.
    always_comb begin
        ram_wr_en_d   = 1'b0;
        ram_rd_en_d   = 1'b0;
        ram_addr_d    = ram_addr_q;
        ram_wr_data_d = ram_wr_data_q;
        if (accept) begin
            ram_wr_en_d   = sel_we;
            ram_rd_en_d   = ~sel_we;
            ram_addr_d    = sel_addr;
            ram_wr_data_d = sel_wdata;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            ram_wr_en_q   <= 1'b0;
            ram_rd_en_q   <= 1'b0;
            ram_addr_q    <= '0;
            ram_wr_data_q <= '0;
        end else begin
            ram_wr_en_q   <= ram_wr_en_d;
            ram_rd_en_q   <= ram_rd_en_d;
            ram_addr_q    <= ram_addr_d;
            ram_wr_data_q <= ram_wr_data_d;
        end
    end

    always_comb begin
        tag_d[0].valid = accept & ~sel_we;
        tag_d[0].port  = sel_port;
        for (int unsigned i = 1; i < TAG_STAGES; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            for (int unsigned i = 0; i < TAG_STAGES; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < TAG_STAGES; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    // The last tag stage lines up with RAM q; reset masks any pulse in flight.
    always_comb begin
        out_tag  = tag_q[TAG_STAGES-1];
        a_rvalid = sys_rst_n & out_tag.valid & (out_tag.port == PORT_A);
        b_rvalid = sys_rst_n & out_tag.valid & (out_tag.port == PORT_B);
    end

    always_comb begin
        a_rdata_d = a_rvalid ? ram_rd_data : a_rdata_q;
        b_rdata_d = b_rvalid ? ram_rd_data : b_rdata_q;
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    assign a_rdata     = a_rdata_d;
    assign b_rdata     = b_rdata_d;
    assign ram_wr_en   = ram_wr_en_q;
    assign ram_rd_en   = ram_rd_en_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wr_data = ram_wr_data_q;

endmodule

// File: doc/ram_arb2.md
RAM_ARB2 -- requirements
Module: ram_arb2

Interface
REQ-001 Parameter ADDR_W, default 5, RAM address width.
REQ-002 Parameter DATA_W, default 8, RAM data width.
REQ-003 sys_clk  in  1  single clock; all logic rising-edge.
REQ-004 sys_rst_n  in  1  reset, synchronous, active-low.
REQ-005 a_req / b_req  in  1  access request, held until granted.
REQ-006 a_we / b_we  in  1  1 = write, 0 = read; valid with req.
REQ-007 a_addr / b_addr  in  ADDR_W  access address.
REQ-008 a_wdata / b_wdata  in  DATA_W  write data.
REQ-009 a_gnt / b_gnt  out  1  access accepted this cycle.
REQ-010 a_rvalid / b_rvalid  out  1  read data valid, one-cycle pulse.
REQ-011 a_rdata / b_rdata  out  DATA_W  read data.
REQ-012 ram_wr_en, ram_rd_en  out  1  RAM port write and read enables.
REQ-013 ram_addr  out  ADDR_W  RAM address.
REQ-014 ram_wr_data  out  DATA_W  RAM write data.
REQ-015 ram_rd_data  in  DATA_W  RAM q; valid one cycle after the RAM samples rden.

Function
REQ-016 Handshake: the transfer is accepted in a cycle where x_req=1 and x_gnt=1; the requester shall hold req, we, addr and wdata stable until then.
REQ-017 x_gnt shall be combinational from x_req and the priority pointer; at most one gnt high per cycle.
REQ-018 With a single request, it shall be granted in the same cycle (zero wait).
REQ-019 With both requesting, grant goes to the port not granted last (round-robin); the pointer updates only on an accepted transfer.
REQ-020 On acceptance, ram_addr, ram_wr_data, ram_wr_en=we, ram_rd_en=!we shall be registered at that clock edge; with no acceptance, both enables are 0 next cycle and addr/data hold.
REQ-021 Read latency: x_rvalid pulses exactly 2 cycles after the gnt cycle; x_rdata = ram_rd_data in that cycle, held until the next rvalid.
REQ-022 An owner tag pipeline (2 stages: valid, port) routes rvalid; no rvalid for writes.
REQ-023 Throughput: one accepted access per cycle, back-to-back, any mix of ports and directions.
REQ-024 A read issued the cycle after a write to the same address returns the new data.
REQ-025 Addresses wrap naturally at 2^ADDR_W; no range checking.
REQ-026 Requests dropped before grant (protocol violation) cause no RAM access.

Reset
REQ-027 During reset: gnt 0, rvalid 0, ram_wr_en 0, ram_rd_en 0, ram_addr 0, ram_wr_data 0, rdata 0, pointer favours port A.
REQ-028 Reset mid-operation discards in-flight reads; no rvalid emitted for them after reset.

Structure
REQ-029 ADDR_W/DATA_W defaults and the latency constant (2) live in a shared header used by ram_arb2 and its bench.
REQ-030 The round-robin grant/pointer logic shall be one sub-module, rr_arb2; ram_arb2 holds the command register and tag pipeline.

Verification
REQ-031 A write addr 3 data 0x5A alone -> a_gnt same cycle, ram_wr_en=1 addr=3 data=0x5A next cycle, no a_rvalid.
REQ-032 B read addr 3 after REQ-031 -> b_gnt, ram_rd_en next cycle, b_rvalid 2 cycles after gnt, b_rdata=0x5A.
REQ-033 A and B both request continuously for 6 cycles from reset -> grants A,B,A,B,A,B.
REQ-034 Back-to-back A write addr 7 = 0x11 then A read addr 7 -> a_rvalid with a_rdata=0x11.
REQ-035 Reads A addr 31 and B addr 0 in consecutive cycles -> rvalids on consecutive cycles, each routed to the correct port.
REQ-036 Reset asserted 1 cycle after a read grant -> no rvalid, all outputs 0, first grant after reset goes to A on contention.
